// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M divide/remainder unit.
package div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    SIGN = 2'b10,
    DONE = 2'b11
  } div_state_e;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  // Two's-complement negate; also serves as magnitude for negative values.
  function automatic logic [31:0] negate(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/div_core.sv
// Unsigned radix-2 restoring divider: load latches operands, each step
// retires one quotient bit, last flags the final step.
module div_core
  import div_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quot,
  output logic [XLEN-1:0] rem,
  output logic            last
);

  localparam logic [5:0] LAST_CNT = 6'(ITER - 1);

  logic [XLEN-1:0] rem_reg;
  logic [XLEN-1:0] quot_reg;
  logic [XLEN-1:0] dsr_reg;
  logic [5:0]      cnt_reg;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // The extra top bit keeps the borrow of the trial subtraction.
  assign shifted = {rem_reg, quot_reg[XLEN-1]};
  assign diff    = shifted - {1'b0, dsr_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_reg  <= '0;
      quot_reg <= '0;
      dsr_reg  <= '0;
      cnt_reg  <= '0;
    end else if (load) begin
      rem_reg  <= '0;
      quot_reg <= dividend;
      dsr_reg  <= divisor;
      cnt_reg  <= '0;
    end else if (step) begin
      if (!diff[XLEN]) begin
        rem_reg  <= diff[XLEN-1:0];
        quot_reg <= {quot_reg[XLEN-2:0], 1'b1};
      end else begin
        rem_reg  <= shifted[XLEN-1:0];
        quot_reg <= {quot_reg[XLEN-2:0], 1'b0};
      end
      cnt_reg <= cnt_reg + 6'd1;
    end
  end

  assign quot = quot_reg;
  assign rem  = rem_reg;
  assign last = (cnt_reg == LAST_CNT);

endmodule

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU wrapper: sign handling, special cases, tag and
// busy/done handshake around the unsigned iterative core.
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  div_state_e      state_reg;
  logic            sel_rem_reg;
  logic            neg_q_reg;
  logic            neg_r_reg;
  logic [4:0]      rd_reg;
  logic [XLEN-1:0] result_reg;
  logic [4:0]      rd_out_reg;

  logic            signed_op;
  logic            neg1;
  logic            neg2;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic            div_zero;
  logic            overflow;
  logic            special;
  logic [XLEN-1:0] special_val;
  logic            accept;
  logic            core_load;
  logic            core_step;
  logic            core_last;
  logic [XLEN-1:0] core_q;
  logic [XLEN-1:0] core_r;
  logic [XLEN-1:0] final_val;

  assign signed_op = ~op[0];
  assign neg1      = signed_op & rs1_val[XLEN-1];
  assign neg2      = signed_op & rs2_val[XLEN-1];
  assign mag1      = neg1 ? negate(rs1_val) : rs1_val;
  assign mag2      = neg2 ? negate(rs2_val) : rs2_val;

  assign div_zero  = (rs2_val == '0);
  assign overflow  = signed_op && (rs1_val == INT_MIN) && (rs2_val == '1);
  assign special   = div_zero | overflow;

  // Divide-by-zero takes precedence; overflow only reachable with non-zero divisor.
  always_comb begin
    special_val = '0;
    if (div_zero) special_val = op[1] ? rs1_val : DIV_BY_ZERO_Q;
    else          special_val = op[1] ? '0      : INT_MIN;
  end

  assign accept    = start & ~flush & ((state_reg == IDLE) || (state_reg == DONE));
  assign core_load = accept & ~special;
  assign core_step = (state_reg == RUN);

  div_core #(.XLEN(XLEN), .ITER(ITER)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .step     (core_step),
    .dividend (mag1),
    .divisor  (mag2),
    .quot     (core_q),
    .rem      (core_r),
    .last     (core_last)
  );

  always_comb begin
    final_val = '0;
    if (sel_rem_reg) final_val = neg_r_reg ? negate(core_r) : core_r;
    else             final_val = neg_q_reg ? negate(core_q) : core_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      sel_rem_reg <= 1'b0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      rd_reg      <= '0;
      result_reg  <= '0;
      rd_out_reg  <= '0;
    end else if (flush) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            sel_rem_reg <= op[1];
            neg_q_reg   <= neg1 ^ neg2;
            neg_r_reg   <= neg1;
            rd_reg      <= rd_in;
            if (special) begin
              result_reg <= special_val;
              rd_out_reg <= rd_in;
              state_reg  <= DONE;
            end else begin
              state_reg  <= RUN;
            end
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          if (core_last) state_reg <= SIGN;
        end
        SIGN: begin
          result_reg <= final_val;
          rd_out_reg <= rd_reg;
          state_reg  <= DONE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy   = (state_reg == RUN) || (state_reg == SIGN);
  assign done   = (state_reg == DONE);
  assign result = result_reg;
  assign rd_out = rd_out_reg;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, results, tags, ignored starts,
// back-to-back issue, flush and reset aborts.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_in;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd_in   (rd_in),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .rd_out  (rd_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one operation from a negedge and follows it up to its done cycle
  // (or 45 cycles). intr_cyc: cycle to present a competing start (0 = none).
  // abort: 0 none, 1 flush in cycle 10, 2 rst in cycle 10.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        input int exp_cyc, input int exp_busy, input int intr_cyc,
                        input int abort);
    int dcyc;
    int bcnt;
    logic [31:0] res;
    logic [4:0]  rdo;
    dcyc = -1;
    bcnt = 0;
    res  = '0;
    rdo  = '0;
    start = 1'b1; op = o; rs1_val = a; rs2_val = b; rd_in = rd;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done && dcyc < 0) begin
        dcyc = n;
        res  = result;
        rdo  = rd_out;
      end
      if (n == 1) start = 1'b0;
      if (intr_cyc != 0 && n == intr_cyc) begin
        start = 1'b1; op = 2'b01; rs1_val = 32'd50; rs2_val = 32'd5; rd_in = 5'd9;
      end
      if (intr_cyc != 0 && n == intr_cyc + 1) start = 1'b0;
      if (abort != 0 && n == 11) begin
        check({tag, "_busy_after_abort"}, 32'(busy), 32'd0);
        if (abort == 2) begin
          check({tag, "_done_after_rst"}, 32'(done), 32'd0);
          check({tag, "_result_after_rst"}, result, 32'd0);
          check({tag, "_rd_after_rst"}, 32'(rd_out), 32'd0);
        end
        flush = 1'b0;
        rst   = 1'b0;
      end
      if (abort == 1 && n == 10) flush = 1'b1;
      if (abort == 2 && n == 10) rst = 1'b1;
      if (dcyc >= 0) break;
    end
    $display("op %s: op=%0d a=0x%08h b=0x%08h rd=%0d -> done_cycle=%0d result=0x%08h rd_out=%0d busy_cycles=%0d",
             tag, o, a, b, rd, dcyc, res, rdo, bcnt);
    check({tag, "_done_cycle"}, dcyc, exp_cyc);
    check({tag, "_busy_cycles"}, bcnt, exp_busy);
    if (exp_cyc > 0) begin
      check({tag, "_result"}, res, exp);
      check({tag, "_rd_out"}, 32'(rdo), 32'(rd));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; rs1_val = '0; rs2_val = '0; rd_in = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_rd_out", 32'(rd_out), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Consecutive calls start in the previous DONE cycle (back-to-back issue).
    run_op("div_20_3",      2'b00, 32'd20,        32'd3,         5'd5,  32'd6,         34, 33, 0, 0);
    run_op("rem_20_3",      2'b10, 32'd20,        32'd3,         5'd6,  32'd2,         34, 33, 0, 0);
    run_op("div_m20_3",     2'b00, 32'hFFFF_FFEC, 32'd3,         5'd7,  32'hFFFF_FFFA, 34, 33, 0, 0);
    run_op("rem_m20_3",     2'b10, 32'hFFFF_FFEC, 32'd3,         5'd8,  32'hFFFF_FFFE, 34, 33, 0, 0);
    run_op("remu_m20_3",    2'b11, 32'hFFFF_FFEC, 32'd3,         5'd9,  32'd2,         34, 33, 0, 0);
    run_op("div_20_m3",     2'b00, 32'd20,        32'hFFFF_FFFD, 5'd10, 32'hFFFF_FFFA, 34, 33, 0, 0);
    run_op("rem_20_m3",     2'b10, 32'd20,        32'hFFFF_FFFD, 5'd11, 32'd2,         34, 33, 0, 0);
    run_op("div_m20_m3",    2'b00, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 5'd12, 32'd6,         34, 33, 0, 0);
    run_op("divu_7_0",      2'b01, 32'd7,         32'd0,         5'd13, 32'hFFFF_FFFF,  1,  0, 0, 0);
    run_op("remu_7_0",      2'b11, 32'd7,         32'd0,         5'd14, 32'd7,          1,  0, 0, 0);
    run_op("div_ovf",       2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000,  1,  0, 0, 0);
    run_op("rem_ovf",       2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,          1,  0, 0, 0);
    run_op("div_min_1",     2'b00, 32'h8000_0000, 32'd1,         5'd17, 32'h8000_0000, 34, 33, 0, 0);
    run_op("divu_max_1",    2'b01, 32'hFFFF_FFFF, 32'd1,         5'd18, 32'hFFFF_FFFF, 34, 33, 0, 0);
    run_op("divu_100_7_ig", 2'b01, 32'd100,       32'd7,         5'd3,  32'd14,        34, 33, 5, 0);

    @(negedge clk);
    check("no_queue_done", 32'(done), 32'd0);
    check("no_queue_busy", 32'(busy), 32'd0);

    run_op("div_flush",     2'b00, 32'd1000,      32'd10,        5'd20, 32'd0,         -1, 10, 0, 1);
    run_op("div_rst",       2'b00, 32'd1000,      32'd10,        5'd21, 32'd0,         -1, 10, 0, 2);
    run_op("div_after_rst", 2'b00, 32'd1000,      32'd10,        5'd22, 32'd100,       34, 33, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
